// File: rtl/mem_dcache_bytelane.sv
// mem_dcache_bytelane: MIPS byte/half/word data memory, one-cycle registered loads, post-reset clear
module mem_dcache_bytelane #(
    parameter int AW = 9,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_req_valid,
    input  logic        in_wr_en,
    input  logic [1:0]  in_size,
    input  logic        in_signed,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wr_data,
    output logic        out_req_ready,
    output logic        out_rd_valid,
    output logic [31:0] out_rd_data,
    output logic        out_misalign,
    output logic        out_init_done
);
    localparam int DEPTH = 1 << AW;
    typedef enum logic {CLEAR, READY} state_t;
    state_t state, state_nx;
    logic [AW-1:0] clr_ptr, idx;
    logic [31:0] mem [DEPTH];
    logic [1:0] off, lane;
    logic [4:0] sh;
    logic rdy, bad, accept, do_wr, unused_addr;
    logic [31:0] mask, wdata, raw, ext;
    assign idx = in_addr[AW+1:2];
    assign off = in_addr[1:0];
    assign unused_addr = ^in_addr[31:AW+2];
    assign accept = in_req_valid & rdy;
    assign bad = (in_size == 2'b11) | ((in_size == 2'b01) & off[0]) | ((in_size == 2'b10) & (|off));
    assign do_wr = accept & in_wr_en & ~bad;
    assign out_req_ready = rdy;
    assign out_init_done = rdy;
    // lane = index of the lowest byte of the access within the 32-bit word
    always_comb begin
        lane = in_size == 2'b00 ? (BIG_ENDIAN ? ~off : off) :
               in_size == 2'b01 ? {(BIG_ENDIAN ? ~off[1] : off[1]), 1'b0} : 2'd0;
        sh = {lane, 3'b000};
        mask = (in_size == 2'b00 ? 32'h0000_00ff : in_size == 2'b01 ? 32'h0000_ffff : 32'hffff_ffff) << sh;
        wdata = in_wr_data << sh;
        raw = mem[idx] >> sh;
        ext = in_size == 2'b00 ? {{24{in_signed & raw[7]}}, raw[7:0]} :
              in_size == 2'b01 ? {{16{in_signed & raw[15]}}, raw[15:0]} : raw;
    end
    always_comb begin
        state_nx = state;
        if (state == CLEAR && &clr_ptr) state_nx = READY;
    end
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            if (CLEAR_ON_RESET) state <= CLEAR;
            else state <= READY;
            clr_ptr <= '0;
            rdy <= 1'b0;
            out_rd_valid <= 1'b0;
            out_misalign <= 1'b0;
            out_rd_data <= '0;
        end else begin
            state <= state_nx;
            clr_ptr <= state == CLEAR ? clr_ptr + AW'(1) : clr_ptr;
            rdy <= state_nx == READY;
            out_rd_valid <= accept & ~in_wr_en;
            out_misalign <= accept & bad;
            if (accept & ~in_wr_en) out_rd_data <= bad ? '0 : ext;
        end
    end
    // the array stays off the reset net; the clear walks it instead
    always_ff @(posedge in_clk) begin
        if (state == CLEAR) mem[clr_ptr] <= '0;
        else if (do_wr) mem[idx] <= (mem[idx] & ~mask) | (wdata & mask);
    end
endmodule

// File: tb/tb_mem_dcache_bytelane.sv
// tb_mem_dcache_bytelane: directed scoreboard bench for a big-endian (AW=9) and a little-endian (AW=4) instance
module tb_mem_dcache_bytelane;
    logic in_clk = 1'b0;
    logic in_rst_n = 1'b0;
    logic req_valid = 1'b0, wr_en = 1'b0, sgn = 1'b0;
    logic [1:0] size = 2'd0;
    logic [31:0] addr = '0, wr_data = '0;
    logic ready0, rd_valid0, mis0, done0, ready1, rd_valid1, mis1, done1;
    logic [31:0] rd_data0, rd_data1;
    int total = 0;
    int bad = 0;
    typedef struct packed {logic ld; logic mis; logic [31:0] d;} exp_t;
    exp_t q0[$];
    exp_t q1[$];

    mem_dcache_bytelane u_be (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_req_valid(req_valid), .in_wr_en(wr_en),
        .in_size(size), .in_signed(sgn), .in_addr(addr), .in_wr_data(wr_data),
        .out_req_ready(ready0), .out_rd_valid(rd_valid0), .out_rd_data(rd_data0),
        .out_misalign(mis0), .out_init_done(done0)
    );
    mem_dcache_bytelane #(.AW(4), .BIG_ENDIAN(1'b0)) u_le (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_req_valid(req_valid), .in_wr_en(wr_en),
        .in_size(size), .in_signed(sgn), .in_addr(addr), .in_wr_data(wr_data),
        .out_req_ready(ready1), .out_rd_valid(rd_valid1), .out_rd_data(rd_data1),
        .out_misalign(mis1), .out_init_done(done1)
    );

    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge in_clk) begin : mon_be
        exp_t e;
        if (rd_valid0 | mis0) begin
            if (q0.size() == 0) chk("be_spurious_pulse", {30'd0, rd_valid0, mis0}, 32'd0);
            else begin
                e = q0.pop_front();
                chk("be_rd_valid", {31'd0, rd_valid0}, {31'd0, e.ld});
                chk("be_misalign", {31'd0, mis0}, {31'd0, e.mis});
                if (e.ld) chk("be_rd_data", rd_data0, e.d);
            end
        end
    end

    always @(negedge in_clk) begin : mon_le
        exp_t e;
        if (rd_valid1 | mis1) begin
            if (q1.size() == 0) chk("le_spurious_pulse", {30'd0, rd_valid1, mis1}, 32'd0);
            else begin
                e = q1.pop_front();
                chk("le_rd_valid", {31'd0, rd_valid1}, {31'd0, e.ld});
                chk("le_misalign", {31'd0, mis1}, {31'd0, e.mis});
                if (e.ld) chk("le_rd_data", rd_data1, e.d);
            end
        end
    end

    task automatic req(input logic w, input logic [1:0] s, input logic sg, input logic [31:0] a,
                       input logic [31:0] d, input logic ld, input logic ms,
                       input logic [31:0] e0, input logic [31:0] e1);
        req_valid = 1'b1; wr_en = w; size = s; sgn = sg; addr = a; wr_data = d;
        if (ld | ms) begin
            q0.push_back({ld, ms, e0});
            q1.push_back({ld, ms, e1});
        end
        @(negedge in_clk);
        req_valid = 1'b0;
    endtask

    task automatic do_st(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        req(1'b1, s, 1'b0, a, d, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic do_ld(input logic [1:0] s, input logic sg, input logic [31:0] a,
                         input logic [31:0] e0, input logic [31:0] e1);
        req(1'b0, s, sg, a, '0, 1'b1, 1'b0, e0, e1);
    endtask

    task automatic check_zero(input string t);
        chk({t, "_be_ready"}, {31'd0, ready0}, 32'd0);
        chk({t, "_be_done"}, {31'd0, done0}, 32'd0);
        chk({t, "_be_valid"}, {31'd0, rd_valid0}, 32'd0);
        chk({t, "_be_mis"}, {31'd0, mis0}, 32'd0);
        chk({t, "_be_data"}, rd_data0, 32'd0);
        chk({t, "_le_ready"}, {31'd0, ready1}, 32'd0);
        chk({t, "_le_done"}, {31'd0, done1}, 32'd0);
        chk({t, "_le_valid"}, {31'd0, rd_valid1}, 32'd0);
        chk({t, "_le_mis"}, {31'd0, mis1}, 32'd0);
        chk({t, "_le_data"}, rd_data1, 32'd0);
    endtask

    // releases reset and counts edges until each instance reports ready
    task automatic wait_ready(input string t, input bit inject);
        int n = 0;
        int c0 = 0;
        int c1 = 0;
        wr_en = 1'b1; size = 2'b10; addr = 32'h0; wr_data = 32'hffff_ffff;
        in_rst_n = 1'b1;
        while (n < 600 && (c0 == 0 || c1 == 0)) begin
            @(posedge in_clk);
            #1;
            n++;
            req_valid = inject && n == 10;
            if (ready0 && c0 == 0) c0 = n;
            if (ready1 && c1 == 0) c1 = n;
        end
        req_valid = 1'b0;
        chk({t, "_be_ready_cycle"}, c0, 32'd512);
        chk({t, "_le_ready_cycle"}, c1, 32'd16);
        chk({t, "_be_init_done"}, {31'd0, done0}, 32'd1);
        chk({t, "_le_init_done"}, {31'd0, done1}, 32'd1);
        @(negedge in_clk);
    endtask

    initial begin
        repeat (3) @(negedge in_clk);
        check_zero("reset");
        wait_ready("boot", 1'b1);
        do_ld(2'b10, 1'b0, 32'h7fc, 32'h0, 32'h0);
        do_ld(2'b10, 1'b0, 32'h000, 32'h0, 32'h0);
        do_st(2'b10, 32'h000, 32'h2b7e_1516);
        do_ld(2'b10, 1'b0, 32'h000, 32'h2b7e_1516, 32'h2b7e_1516);
        do_st(2'b10, 32'h010, 32'h0);
        do_st(2'b00, 32'h011, 32'hffff_ffa8);
        do_ld(2'b10, 1'b0, 32'h010, 32'h00a8_0000, 32'h0000_a800);
        do_ld(2'b00, 1'b1, 32'h011, 32'hffff_ffa8, 32'hffff_ffa8);
        do_ld(2'b00, 1'b0, 32'h011, 32'h0000_00a8, 32'h0000_00a8);
        do_ld(2'b01, 1'b1, 32'h010, 32'h0000_00a8, 32'hffff_a800);
        do_st(2'b10, 32'h020, 32'h0);
        do_st(2'b01, 32'h022, 32'h1234_beef);
        do_ld(2'b10, 1'b0, 32'h020, 32'h0000_beef, 32'hbeef_0000);
        do_ld(2'b01, 1'b0, 32'h022, 32'h0000_beef, 32'h0000_beef);
        do_ld(2'b01, 1'b1, 32'h022, 32'hffff_beef, 32'hffff_beef);
        do_ld(2'b00, 1'b0, 32'h023, 32'h0000_00ef, 32'h0000_00be);
        req(1'b1, 2'b01, 1'b0, 32'h003, 32'h1234, 1'b0, 1'b1, '0, '0);
        req(1'b0, 2'b10, 1'b0, 32'h002, '0, 1'b1, 1'b1, '0, '0);
        req(1'b0, 2'b11, 1'b0, 32'h000, '0, 1'b1, 1'b1, '0, '0);
        req(1'b1, 2'b10, 1'b0, 32'h001, 32'hffff_ffff, 1'b0, 1'b1, '0, '0);
        req(1'b1, 2'b11, 1'b0, 32'h000, 32'hffff_ffff, 1'b0, 1'b1, '0, '0);
        do_ld(2'b10, 1'b0, 32'h000, 32'h2b7e_1516, 32'h2b7e_1516);
        do_ld(2'b00, 1'b0, 32'h003, 32'h0000_0016, 32'h0000_002b);
        do_ld(2'b00, 1'b0, 32'h000, 32'h0000_002b, 32'h0000_0016);
        do_ld(2'b01, 1'b1, 32'h002, 32'h0000_1516, 32'h0000_2b7e);
        do_st(2'b10, 32'h800, 32'h5a5a_5a5a);
        do_ld(2'b10, 1'b0, 32'h000, 32'h5a5a_5a5a, 32'h5a5a_5a5a);
        do_st(2'b00, 32'h004, 32'h77);
        chk("hold_be_data", rd_data0, 32'h5a5a_5a5a);
        chk("hold_le_data", rd_data1, 32'h5a5a_5a5a);
        chk("store_be_no_valid", {31'd0, rd_valid0}, 32'd0);
        // a load in flight when reset hits must lose its pulse
        req_valid = 1'b1; wr_en = 1'b0; size = 2'b10; addr = 32'h0;
        @(posedge in_clk);
        #1;
        req_valid = 1'b0;
        in_rst_n = 1'b0;
        #1;
        check_zero("rst_pending");
        @(negedge in_clk);
        in_rst_n = 1'b1;
        repeat (100) @(posedge in_clk);
        #1;
        chk("le_ready_before_midreset", {31'd0, ready1}, 32'd1);
        in_rst_n = 1'b0;
        #1;
        check_zero("rst_midclear");
        @(negedge in_clk);
        wait_ready("reclear", 1'b0);
        do_ld(2'b10, 1'b0, 32'h000, 32'h0, 32'h0);
        do_ld(2'b10, 1'b0, 32'h7fc, 32'h0, 32'h0);
        repeat (2) @(negedge in_clk);
        chk("be_queue_drained", q0.size(), 32'd0);
        chk("le_queue_drained", q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
